multi_port_queue: RTL

//  Parametrised superscalar circular FIFO: up to ENQ_WIDTH entries in and DEQ_WIDTH entries out per cycle.
//  Has a synchronous flush and an occupancy count. Generalises the single-port queue.

---
 rtl/multi_port_queue_pkg.sv | 12 +
 rtl/multi_port_queue_ptr_ctr.sv | 23 ++
 rtl/multi_port_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/multi_port_queue_pkg.sv
// Shared sizing defaults and pointer type for the multi-issue queue.
// Optional zero-latency bypass is enabled by defining QUEUE_BYPASS_EN.
package multi_port_queue_pkg;

    localparam int unsigned QUEUE_DEPTH_DEF  = 16;
    localparam int unsigned QUEUE_LANES_DEF  = 2;
    localparam int unsigned QUEUE_ADDR_W_DEF = $clog2(QUEUE_DEPTH_DEF);

    // Wrap-bit pointer for the default depth: MSB is the lap bit.
    typedef logic [QUEUE_ADDR_W_DEF:0] queue_ptr_t;

endpackage

// File: rtl/multi_port_queue_ptr_ctr.sv
// Wrap-bit pointer register: cleared by rst or flush, otherwise advances by inc.
module queue_ptr_ctr
    import multi_port_queue_pkg::*;
#(
    parameter int unsigned PTR_W = QUEUE_ADDR_W_DEF + 1,
    parameter int unsigned INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [INC_W-1:0] inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + PTR_W'(inc);
        end
    end

endmodule

// File: rtl/multi_port_queue.sv
// Superscalar circular FIFO: up to ENQ_WIDTH pushes and DEQ_WIDTH pops per cycle.
// Define QUEUE_BYPASS_EN to forward enqueue lanes straight to dequeue lanes when empty.
module multi_port_queue
    import multi_port_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int unsigned ENQ_WIDTH   = QUEUE_LANES_DEF,
    parameter int unsigned DEQ_WIDTH   = QUEUE_LANES_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_in,
    input  logic [ENQ_WIDTH-1:0]            enq_valid_in,
    input  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data_in,
    output logic                            enq_ready_out,
    output logic [DEQ_WIDTH-1:0]            deq_valid_out,
    output logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data_out,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]  deq_pop_in,
    output logic [$clog2(QUEUE_DEPTH):0]    count_out
);

    localparam int unsigned ADDR_W   = $clog2(QUEUE_DEPTH);
    localparam int unsigned PTR_W    = ADDR_W + 1;
    localparam int unsigned LANE_MAX = (ENQ_WIDTH > DEQ_WIDTH) ? ENQ_WIDTH : DEQ_WIDTH;
    localparam int unsigned LANE_W   = $clog2(LANE_MAX + 1);

    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];

    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W-1:0]     count;
    logic [PTR_W-1:0]     avail;
    logic [PTR_W-1:0]     pop_req;
    logic [LANE_W-1:0]    enq_n;
    logic [LANE_W-1:0]    pop_n;
    logic [LANE_W-1:0]    tail_inc;
    logic                 accept;
    logic                 bypass;
    logic [ENQ_WIDTH-1:0] wr_en;

    assign count         = tail - head;
    assign count_out     = count;
    assign enq_ready_out = (PTR_W'(QUEUE_DEPTH) - count) >= PTR_W'(ENQ_WIDTH);

    // Accept/pop bookkeeping; pops are clipped to what is actually visible.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            enq_n = enq_n + LANE_W'(enq_valid_in[i]);
        end
        accept = enq_ready_out && !flush_in && (enq_n != '0);
`ifdef QUEUE_BYPASS_EN
        bypass = accept && (count == '0);
`else
        bypass = 1'b0;
`endif
        avail    = bypass ? PTR_W'(enq_n) : count;
        pop_req  = PTR_W'(deq_pop_in);
        pop_n    = (pop_req < avail) ? LANE_W'(pop_req) : LANE_W'(avail);
        tail_inc = accept ? enq_n : '0;
        wr_en    = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            // Lanes consumed by a same-cycle bypass pop never land in storage.
            wr_en[i] = accept && enq_valid_in[i] && !(bypass && (LANE_W'(i) < pop_n));
        end
    end

    queue_ptr_ctr #(.PTR_W(PTR_W), .INC_W(LANE_W)) u_head (
        .clk  (clk),
        .rst  (rst),
        .flush(flush_in),
        .inc  (pop_n),
        .ptr  (head)
    );

    queue_ptr_ctr #(.PTR_W(PTR_W), .INC_W(LANE_W)) u_tail (
        .clk  (clk),
        .rst  (rst),
        .flush(flush_in),
        .inc  (tail_inc),
        .ptr  (tail)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (wr_en[i]) begin
                mem[tail[ADDR_W-1:0] + ADDR_W'(i)] <= enq_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < DEQ_WIDTH; g++) begin : g_deq
        logic [ADDR_W-1:0]     rd_idx;
        logic                  reg_valid;
        logic [DATA_WIDTH-1:0] reg_data;

        assign rd_idx    = head[ADDR_W-1:0] + ADDR_W'(g);
        assign reg_valid = count > PTR_W'(g);
        assign reg_data  = mem[rd_idx];

`ifdef QUEUE_BYPASS_EN
        if (g < ENQ_WIDTH) begin : g_byp
            assign deq_valid_out[g] = bypass ? enq_valid_in[g] : reg_valid;
            assign deq_data_out[g*DATA_WIDTH +: DATA_WIDTH] =
                bypass ? enq_data_in[g*DATA_WIDTH +: DATA_WIDTH] : reg_data;
        end else begin : g_nobyp
            assign deq_valid_out[g] = reg_valid;
            assign deq_data_out[g*DATA_WIDTH +: DATA_WIDTH] = reg_data;
        end
`else
        assign deq_valid_out[g] = reg_valid;
        assign deq_data_out[g*DATA_WIDTH +: DATA_WIDTH] = reg_data;
`endif
    end

endmodule
